// File: rtl/cnn_wb_pkg.sv
// ============================================================================
//  Package     : cnn_wb_pkg
//  Description : Shared types, default widths and the round-robin helper for
//                the weight/bias fetch arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_wb_pkg;

    // Sequencer states, explicitly two bits wide
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        FIN    = 2'd3
    } wb_state_t;

    localparam int NUM_REQ_DEF   = 3;
    localparam int BIT_WIDTH_DEF = 8;
    localparam int ADDR_W_DEF    = 12;

    // Depth of the consumer-side skid buffer (backpressure builds only)
    localparam int SKID_DEPTH    = 2;

    // The helper works on a fixed-width request vector; NUM_REQ must not exceed RR_MAX
    localparam int RR_IW         = 4;
    localparam int RR_MAX        = 1 << RR_IW;

    // First set bit of req searching upward from ptr, wrapping at n.
    // Walking k downward makes the smallest distance from ptr the final winner.
    function automatic int rr_first(input logic [RR_MAX-1:0] req, input int ptr, input int n);
        int               idx;
        logic [RR_IW-1:0] sel;
        rr_first = ptr;
        for (int k = RR_MAX - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (ptr + k) % n;
                sel = RR_IW'(idx);
                if (req[sel]) begin
                    rr_first = idx;
                end
            end
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_skid_buf.sv
// ============================================================================
//  Module      : wb_skid_buf
//  Description : Two-entry FIFO that absorbs the read still in flight when the
//                consumer stalls. The head entry drives the output directly
//                from a register, so the output holds stable while stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_skid_buf #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_ent0;
    logic [W-1:0] r_ent1;
    logic [1:0]   r_cnt;
    logic         w_pop;

    assign w_pop   = (r_cnt != 2'd0) && i_ready;
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_ent0;
    assign o_count = r_cnt;

    // Push/pop bookkeeping; entry 0 is always the head of the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ent0 <= '0;
            r_ent1 <= '0;
            r_cnt  <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_ent0 <= i_data;
                    else               r_ent1 <= i_data;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_ent0 <= r_ent1;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_ent0 <= i_data;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_fetch_arbiter.sv
// ============================================================================
//  Module      : wb_fetch_arbiter
//  Description : Round-robin arbiter plus streaming sequencer that shares one
//                1-cycle-latency parameter memory among NUM_REQ layer engines.
//                Optional macro WB_BACKPRESSURE_EN honours wt_ready through a
//                two-entry skid buffer; without it wt_ready is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fetch_arbiter
    import cnn_wb_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int BIT_WIDTH = BIT_WIDTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_base,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_len,
    output logic                        mem_rd_en,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [BIT_WIDTH-1:0]        mem_rdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [BIT_WIDTH-1:0]        wt_data,
    output logic                        wt_valid,
    output logic                        wt_last,
    input  logic                        wt_ready,
    output logic [NUM_REQ-1:0]          done
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    wb_state_t            r_state;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_done;
    logic [IDX_W-1:0]     r_gidx;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [ADDR_W-1:0]    r_base;
    logic [ADDR_W-1:0]    r_len;
    logic [ADDR_W-1:0]    r_cnt;
    logic                 r_rd_d1;       // a read was issued last cycle; its data is on mem_rdata now
    logic                 r_rd_last_d1;  // ... and it was the final read of the transfer

    logic [IDX_W-1:0]     w_pick;
    logic [ADDR_W-1:0]    w_pick_base;
    logic [ADDR_W-1:0]    w_pick_len;
    logic                 w_credit;
    logic                 w_rd;
    logic                 w_rd_last;
    logic                 w_last_done;

    assign w_pick      = IDX_W'(rr_first(RR_MAX'(req), int'(r_rr_ptr), NUM_REQ));
    assign w_pick_base = req_base[w_pick*ADDR_W +: ADDR_W];
    assign w_pick_len  = req_len[w_pick*ADDR_W +: ADDR_W];

    // Reads depend on the consumer's ready when backpressure is built, so the
    // strobe is decoded from registered state rather than registered itself
    assign w_rd      = (r_state == STREAM) && w_credit;
    assign w_rd_last = w_rd && (r_cnt == r_len - ADDR_W'(1));
    assign mem_rd_en = w_rd;
    assign mem_addr  = w_rd ? (r_base + r_cnt) : '0;
    assign gnt       = r_gnt;
    assign done      = r_done;

`ifdef WB_BACKPRESSURE_EN
    logic                 w_sk_valid;
    logic [BIT_WIDTH:0]   w_sk_data;
    logic [1:0]           w_sk_cnt;
    logic [2:0]           w_occ_next;

    // Occupancy once this cycle's pop and the in-flight push settle; a new read
    // is allowed only if it still finds a free slot when its data lands
    assign w_occ_next  = 3'(w_sk_cnt) - 3'(w_sk_valid && wt_ready) + 3'(r_rd_d1);
    assign w_credit    = (w_occ_next < 3'(SKID_DEPTH));
    assign w_last_done = w_sk_valid && w_sk_data[BIT_WIDTH] && wt_ready;

    wb_skid_buf #(
        .W (BIT_WIDTH + 1)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_rd_d1),
        .i_data  ({r_rd_last_d1, mem_rdata}),
        .i_ready (wt_ready),
        .o_valid (w_sk_valid),
        .o_data  (w_sk_data),
        .o_count (w_sk_cnt)
    );

    assign wt_valid = w_sk_valid;
    assign wt_data  = w_sk_data[BIT_WIDTH-1:0];
    assign wt_last  = w_sk_data[BIT_WIDTH];
`else
    logic                 r_wt_valid;
    logic [BIT_WIDTH-1:0] r_wt_data;
    logic                 r_wt_last;
    logic                 w_unused_ready;

    assign w_unused_ready = wt_ready;
    assign w_credit       = 1'b1;
    // The last word is being captured into the output register this cycle
    assign w_last_done    = r_rd_d1 && r_rd_last_d1;

    // Output stage: each returned word is registered once, one cycle after its read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wt_valid <= 1'b0;
            r_wt_data  <= '0;
            r_wt_last  <= 1'b0;
        end else begin
            r_wt_valid <= r_rd_d1;
            r_wt_last  <= r_rd_d1 && r_rd_last_d1;
            if (r_rd_d1) r_wt_data <= mem_rdata;
        end
    end

    assign wt_valid = r_wt_valid;
    assign wt_data  = r_wt_data;
    assign wt_last  = r_wt_last;
`endif

    // Arbitration and transfer sequencing, with grant/done registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_gnt        <= '0;
            r_done       <= '0;
            r_gidx       <= '0;
            r_rr_ptr     <= '0;
            r_base       <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_rd_d1      <= 1'b0;
            r_rd_last_d1 <= 1'b0;
        end else begin
            r_done       <= '0;
            r_rd_d1      <= w_rd;
            r_rd_last_d1 <= w_rd_last;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_gidx  <= w_pick;
                        r_gnt   <= NUM_REQ'(1) << w_pick;
                        r_base  <= w_pick_base;
                        r_len   <= w_pick_len;
                        r_cnt   <= '0;
                        r_state <= (w_pick_len != '0) ? STREAM : FIN;
                    end
                end
                STREAM: begin
                    if (w_rd) begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                        if (w_rd_last) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_last_done) r_state <= FIN;
                end
                FIN: begin
                    r_done   <= r_gnt;
                    r_gnt    <= '0;
                    r_rr_ptr <= (r_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gidx + IDX_W'(1);
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_fetch_arbiter.sv
// ============================================================================
//  Module      : tb_wb_fetch_arbiter
//  Description : Directed self-checking bench for wb_fetch_arbiter. Expected
//                read addresses and streamed words are queued when a transfer
//                is launched and consumed as the design produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_fetch_arbiter;

    localparam int NR = 3;
    localparam int BW = 8;
    localparam int AW = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*AW-1:0]  req_base;
    logic [NR*AW-1:0]  req_len;
    logic              mem_rd_en;
    logic [AW-1:0]     mem_addr;
    logic [BW-1:0]     mem_rdata = '0;
    logic [NR-1:0]     gnt;
    logic [BW-1:0]     wt_data;
    logic              wt_valid;
    logic              wt_last;
    logic              wt_ready;
    logic [NR-1:0]     done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0] exp_addr_q[$];
    logic [BW:0]   exp_word_q[$];   // {last, data}

    wb_fetch_arbiter #(.NUM_REQ(NR), .BIT_WIDTH(BW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_base  (req_base),
        .req_len   (req_len),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .gnt       (gnt),
        .wt_data   (wt_data),
        .wt_valid  (wt_valid),
        .wt_last   (wt_last),
        .wt_ready  (wt_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Memory model: returns the low address byte one cycle after the read
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem_addr[7:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: read addresses, accepted beats, stall stability
    logic        prev_stall = 1'b0;
    logic [BW:0] prev_word  = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd_en) begin
                if (exp_addr_q.size() == 0) chk("unexpected_read", 32'(mem_addr), 32'hFFFF_FFFF);
                else                        chk("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(wt_valid), 32'd1);
                chk("stall_word", 32'({wt_last, wt_data}), 32'(prev_word));
            end
            if (wt_valid && wt_ready) begin
                if (exp_word_q.size() == 0) chk("unexpected_beat", 32'({wt_last, wt_data}), 32'hFFFF_FFFF);
                else                        chk("beat", 32'({wt_last, wt_data}), 32'(exp_word_q.pop_front()));
            end
            prev_stall = wt_valid && !wt_ready;
            prev_word  = {wt_last, wt_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push_xfer(input logic [AW-1:0] base, input int len);
        logic [AW-1:0] a;
        for (int i = 0; i < len; i++) begin
            a = base + AW'(i);
            exp_addr_q.push_back(a);
            exp_word_q.push_back({(i == len - 1), a[7:0]});
        end
    endtask

    task automatic set_slot(input int s, input logic [AW-1:0] base, input logic [AW-1:0] len);
        req_base[s*AW +: AW] = base;
        req_len[s*AW +: AW]  = len;
    endtask

    task automatic rst_pulse();
        @(negedge clk); #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    // Waits (bounded) for a done pulse; reports whether wt_last preceded it
    task automatic wait_done(output logic saw_last);
        int cyc = 0;
        saw_last = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (done != '0 || cyc > 200) break;
            if (wt_valid && wt_last) saw_last = 1'b1;
        end
        chk("done_timeout", 32'(done != '0), 32'd1);
    endtask

    // Launches a request (inputs change away from the sampling edge), checks
    // the grant one cycle later and the done pulse at the end
    task automatic run_xfer(input string tag, input logic [NR-1:0] rq, input logic [NR-1:0] expg);
        logic sl;
        @(negedge clk); #1 req = rq;
        @(negedge clk);
        chk({tag, "_gnt"}, 32'(gnt), 32'(expg));
        wait_done(sl);
        chk({tag, "_done"}, 32'(done), 32'(expg));
        chk({tag, "_gnt_clr"}, 32'(gnt), 32'd0);
        #1 req = '0;
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic sl;
        int   beats;
        rst      = 1'b1;
        req      = '0;
        req_base = '0;
        req_len  = '0;
        wt_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wt_valid", 32'(wt_valid), 32'd0);
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        #1 rst = 1'b0;

        // 1: single transfer, base 0x010, len 4
        set_slot(0, 12'h010, 12'd4);
        push_xfer(12'h010, 4);
        @(negedge clk);
        chk("t1_gnt_pre", 32'(gnt), 32'd0);
        #1 req = 3'b001;
        @(negedge clk);
        chk("t1_gnt", 32'(gnt), 32'b001);
        @(negedge clk);
        chk("t1_valid_early", 32'(wt_valid), 32'd0);
        @(negedge clk);
        chk("t1_first_valid", 32'(wt_valid), 32'd1);
        wait_done(sl);
        chk("t1_done", 32'(done), 32'b001);
        chk("t1_last_before_done", 32'(sl), 32'd1);
        chk("t1_no_beat_at_done", 32'(wt_valid), 32'd0);
        chk("t1_gnt_clr", 32'(gnt), 32'd0);
        #1 req = '0;
        @(negedge clk);
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_sb_words", 32'(exp_word_q.size()), 32'd0);

        // 2: all three requesting, len 2 each -> 001,010,100,001 with IDLE gaps
        rst_pulse();
        set_slot(0, 12'h100, 12'd2);
        set_slot(1, 12'h200, 12'd2);
        set_slot(2, 12'h300, 12'd2);
        push_xfer(12'h100, 2);
        push_xfer(12'h200, 2);
        push_xfer(12'h300, 2);
        push_xfer(12'h100, 2);
        @(negedge clk); #1 req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            logic [NR-1:0] eg;
            eg = NR'(1) << (k % 3);
            @(negedge clk);
            chk($sformatf("t2_gnt%0d", k), 32'(gnt), 32'(eg));
            wait_done(sl);
            chk($sformatf("t2_done%0d", k), 32'(done), 32'(eg));
            chk($sformatf("t2_idle_gap%0d", k), 32'(gnt), 32'd0);
            if (k == 3) #1 req = '0;
        end
        @(negedge clk);
        chk("t2_quiet", 32'(gnt | done), 32'd0);
        chk("t2_sb_words", 32'(exp_word_q.size()), 32'd0);

        // 3: address wrap at the top of memory
        set_slot(0, 12'hFFE, 12'd4);
        push_xfer(12'hFFE, 4);
        run_xfer("t3", 3'b001, 3'b001);
        chk("t3_sb_addr", 32'(exp_addr_q.size()), 32'd0);

        // 4: zero-length transfer on requester 1
        set_slot(1, 12'h050, 12'd0);
        @(negedge clk); #1 req = 3'b010;
        @(negedge clk);
        chk("t4_gnt", 32'(gnt), 32'b010);
        chk("t4_done_early", 32'(done), 32'd0);
        @(negedge clk);
        chk("t4_gnt_clr", 32'(gnt), 32'd0);
        chk("t4_done", 32'(done), 32'b010);
        #1 req = '0;
        @(negedge clk);
        chk("t4_done_pulse", 32'(done), 32'd0);

        // 5: reset on the 3rd beat of a len 8 transfer
        set_slot(0, 12'h020, 12'd8);
        push_xfer(12'h020, 8);
        @(negedge clk); #1 req = 3'b001;
        beats = 0;
        for (int c = 0; c < 40 && beats < 3; c++) begin
            @(negedge clk);
            if (wt_valid) beats++;
        end
        chk("t5_beats_seen", 32'(beats), 32'd3);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t5_gnt", 32'(gnt), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_outs", 32'({wt_valid, wt_last, wt_data, mem_rd_en}), 32'd0);
        chk("t5_addr", 32'(mem_addr), 32'd0);
        exp_addr_q.delete();
        exp_word_q.delete();
        #1 begin rst = 1'b0; req = '0; end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t5_no_done", 32'(done | 3'(wt_valid)), 32'd0);
        end
        // rr_ptr back at 0: {2,1} requesting must grant 1, word 0 first
        set_slot(1, 12'h020, 12'd8);
        set_slot(2, 12'h0A0, 12'd3);
        push_xfer(12'h020, 8);
        run_xfer("t5_restart", 3'b110, 3'b010);
        chk("t5_sb_words", 32'(exp_word_q.size()), 32'd0);

`ifdef WB_BACKPRESSURE_EN
        // 6: consumer stalls for three cycles early in a len 6 stream
        set_slot(0, 12'h040, 12'd6);
        push_xfer(12'h040, 6);
        @(negedge clk); #1 req = 3'b001;
        for (int c = 0; c < 20 && !wt_valid; c++) @(negedge clk);
        chk("t6_first_beat", 32'(wt_valid), 32'd1);
        @(posedge clk); #1 wt_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 wt_ready = 1'b1;
        wait_done(sl);
        chk("t6_done", 32'(done), 32'b001);
        chk("t6_last_before_done", 32'(sl), 32'd1);
        #1 req = '0;
        @(negedge clk);
        chk("t6_sb_words", 32'(exp_word_q.size()), 32'd0);
        chk("t6_sb_addr", 32'(exp_addr_q.size()), 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("final_sb_words", 32'(exp_word_q.size()), 32'd0);
        chk("final_sb_addr", 32'(exp_addr_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
